// File: rtl/fpu_sgn_pkg.sv
// Shared types for the floating-point sign-injection pipeline.
package fpu_sgn_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        FABS   = 3'd0,
        FNEG   = 3'd1,
        FSGNJ  = 3'd2,
        FSGNJN = 3'd3,
        FSGNJX = 3'd4,
        FMV    = 3'd5
    } fsgn_mode_t;

endpackage

// File: rtl/fsgn_core.sv
// Combinational sign-injection: only the sign bit of op_a is ever replaced.
module fsgn_core
    import fpu_sgn_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]      op_a,
    input  logic [W-1:0]      op_b,
    input  logic [MODE_W-1:0] mode,
    output logic [W-1:0]      result,
    output logic              illegal
);

    logic sgn;

    always_comb begin
        sgn     = op_a[W-1];
        illegal = 1'b0;
        case (mode)
            FABS:    sgn = 1'b0;
            FNEG:    sgn = ~op_a[W-1];
            FSGNJ:   sgn = op_b[W-1];
            FSGNJN:  sgn = ~op_b[W-1];
            FSGNJX:  sgn = op_a[W-1] ^ op_b[W-1];
            FMV:     sgn = op_a[W-1];
            default: illegal = 1'b1;
        endcase
        // NaN payloads and all other encodings pass through untouched
        result = {sgn, op_a[W-2:0]};
    end

endmodule

// File: rtl/fsgn_pipe.sv
// Sign-injection unit followed by a STAGES-deep valid/ready register pipeline.
module fsgn_pipe
    import fpu_sgn_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRA_W  = 23,
    parameter int STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+FRA_W:0]   op_a,
    input  logic [EXP_W+FRA_W:0]   op_b,
    input  logic [MODE_W-1:0]      mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+FRA_W:0]   result,
    output logic                   illegal
);

    localparam int W = 1 + EXP_W + FRA_W;

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("fsgn_pipe: STAGES must be 1..4");
    end

    logic [W-1:0]      core_res;
    logic              core_ill;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] ill;
    logic [W-1:0]      res [STAGES];
    logic [STAGES:0]   rdy;

    fsgn_core #(
        .W (W)
    ) u_core (
        .op_a    (op_a),
        .op_b    (op_b),
        .mode    (mode),
        .result  (core_res),
        .illegal (core_ill)
    );

    // rdy[k]: stage k can load this cycle (empty, or its beat moves on)
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = ~vld[k] | rdy[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic         v_in;
        logic         i_in;
        logic [W-1:0] r_in;
        logic         vld_q;
        logic         ill_q;
        logic [W-1:0] res_q;

        if (k == 0) begin : g_head
            assign v_in = in_valid;
            assign r_in = core_res;
            assign i_in = core_ill;
        end else begin : g_link
            assign v_in = vld[k-1];
            assign r_in = res[k-1];
            assign i_in = ill[k-1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                ill_q <= 1'b0;
                res_q <= '0;
            end else if (rdy[k]) begin
                vld_q <= v_in;
                if (v_in) begin
                    ill_q <= i_in;
                    res_q <= r_in;
                end
            end
        end

        assign vld[k] = vld_q;
        assign ill[k] = ill_q;
        assign res[k] = res_q;
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld[STAGES-1];
    assign result    = res[STAGES-1];
    assign illegal   = ill[STAGES-1];

endmodule

// File: doc/fsgn_pipe.md
FSGN_PIPE -- requirements
Module: fsgn_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 SHALL have parameter FRA_W, default 23, meaning fraction field width; word width W = 1+EXP_W+FRA_W.
REQ-003 SHALL have parameter STAGES, default 2, legal 1..4, meaning pipeline depth in cycles.
REQ-004 Clock and reset SHALL be: clk  input  1  single clock; rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand/mode beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL have port op_a  input  W  magnitude source operand.
REQ-008 SHALL have port op_b  input  W  sign source operand (ignored by FABS, FNEG, FMV).
REQ-009 SHALL have port mode  input  3  operation select, fsgn_mode_t.
REQ-010 SHALL have port out_valid  output  1  result beat present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  W  operation result.
REQ-013 SHALL have port illegal  output  1  mode of this result beat was unencoded.

Function
REQ-014 Modes SHALL be: 0 FABS sign=0; 1 FNEG sign=~a.s; 2 FSGNJ sign=b.s; 3 FSGNJN sign=~b.s; 4 FSGNJX sign=a.s^b.s; 5 FMV sign=a.s; 6,7 illegal.
REQ-015 Exponent and fraction of result SHALL equal op_a bits [W-2:0] unchanged in every mode, including NaN, Inf, zero and denormal inputs; no NaN canonicalisation.
REQ-016 Illegal modes SHALL return op_a unchanged with illegal=1; all legal modes SHALL return illegal=0.
REQ-017 Handshake: beat transfers at input when in_valid&&in_ready, at output when out_valid&&out_ready.
REQ-018 SHALL be STAGES register stages, each holding valid, result, illegal; compute occurs before stage 1.
REQ-019 Stage k SHALL load from stage k-1 when stage k empty or stage k advancing; otherwise hold.
REQ-020 in_ready SHALL equal ~stage1.valid | stage1 advancing (combinational from out_ready chain, no bubble).
REQ-021 Latency SHALL be exactly STAGES cycles from input transfer to out_valid under out_ready=1.
REQ-022 Throughput SHALL be one beat per cycle with out_ready held 1.
REQ-023 With out_ready=0, pipeline SHALL fill to STAGES beats, then deassert in_ready; result/illegal SHALL stay stable while out_valid&&!out_ready.
REQ-024 Beats SHALL leave in acceptance order; none dropped or duplicated.
REQ-025 Simultaneous output drain and input accept on a full pipe SHALL both occur same cycle.
REQ-026 in_valid with in_ready=0 SHALL not be captured; op_a/op_b/mode may change freely until accepted.

Reset
REQ-027 On rst=1 at clk edge all stage valid bits SHALL clear; out_valid=0, illegal=0, result=0.
REQ-028 in_ready SHALL be 1 in the cycle after reset deasserts.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; no stale beat emitted afterward.
REQ-030 Data registers SHALL reset to 0.

Structure
REQ-031 Package fpu_sgn_pkg SHALL hold fsgn_mode_t enum (FABS..FMV) and mode-width constant.
REQ-032 Combinational sign logic SHALL be sub-module fsgn_core (op_a, op_b, mode -> result, illegal), instantiated once.
REQ-033 Pipeline stages SHALL be a generate over STAGES; no other sub-modules.

Verification
REQ-034 Reset, then FABS op_a=32'hBF800000 -> result 32'h3F800000, illegal 0, out_valid exactly 2 cycles later.
REQ-035 FSGNJX op_a=32'hC0000000, op_b=32'h80000000 -> 32'h40000000; FSGNJN same operands -> 32'h40000000; FSGNJ -> 32'hC0000000.
REQ-036 NaN 32'hFFC00001, FNEG -> 32'h7FC00001; mode 7, op_a=32'h12345678 -> 32'h12345678, illegal 1.
REQ-037 out_ready=0, push 3 beats: 2 accepted, in_ready low, results stable; release -> ordered drain, 1 beat/cycle.
REQ-038 10000 random op_a/op_b/mode with random out_ready -> every result matches scoreboard model, in order.
REQ-039 Assert rst with 2 beats in flight -> out_valid 0 next cycle, no stale beat after release.
